// File: rtl/ped_signal_controller.sv
// Pedestrian crossing controller: car lamps, walk/flash pedestrian phase, countdown
// and animation selects for a matrix display. All outputs are registered.
module ped_signal_controller #(
  parameter int MIN_GREEN = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 1,
  parameter int WALK_T    = 15,
  parameter int FLASH_T   = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       frame_tick,
  input  logic       req,
  output logic       pattern,
  output logic [1:0] sel,
  output logic       blank,
  output logic       car_r,
  output logic       car_y,
  output logic       car_g,
  output logic [5:0] walk_sec,
  output logic       pending
);

  typedef enum logic [2:0] {GREEN, YELLOW, ALLRED, WALK, FLASH} state_t;

  localparam logic [5:0] MIN_GREEN_W = 6'(MIN_GREEN);
  localparam logic [5:0] YELLOW_W    = 6'(YELLOW_T);
  localparam logic [5:0] ALLRED_W    = 6'(ALLRED_T);
  localparam logic [5:0] WALK_W      = 6'(WALK_T);
  localparam logic [5:0] FLASH_W     = 6'(FLASH_T);

  state_t     state;
  state_t     state_nxt;
  logic [5:0] timer;
  logic [5:0] timer_nxt;
  logic       ped_nxt;
  logic       walk_entry;

  function automatic logic [5:0] duration(input state_t s);
    unique case (s)
      GREEN:   duration = MIN_GREEN_W;
      YELLOW:  duration = YELLOW_W;
      ALLRED:  duration = ALLRED_W;
      WALK:    duration = WALK_W;
      FLASH:   duration = FLASH_W;
      default: duration = MIN_GREEN_W;
    endcase
  endfunction

  function automatic state_t advance(input state_t s);
    unique case (s)
      YELLOW:  advance = ALLRED;
      ALLRED:  advance = WALK;
      WALK:    advance = FLASH;
      default: advance = GREEN;
    endcase
  endfunction

  // NOTE: every signal assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_nxt = state;
    timer_nxt = timer;
    if (state == GREEN) begin
      // Leaving GREEN depends only on the expired timer and a latched request, not on tick.
      if (timer == 6'd0 && pending) state_nxt = YELLOW;
      else if (tick && timer != 6'd0) timer_nxt = timer - 6'd1;
    end else if (tick) begin
      if (timer == 6'd1) state_nxt = advance(state);
      else if (timer != 6'd0) timer_nxt = timer - 6'd1;
    end
    if (state_nxt != state) timer_nxt = duration(state_nxt);
  end

  assign ped_nxt    = (state_nxt == WALK) || (state_nxt == FLASH);
  assign walk_entry = (state == ALLRED) && (state_nxt == WALK);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= GREEN;
      timer    <= MIN_GREEN_W;
      pending  <= 1'b0;
      pattern  <= 1'b0;
      sel      <= 2'd0;
      blank    <= 1'b0;
      car_g    <= 1'b1;
      car_y    <= 1'b0;
      car_r    <= 1'b0;
      walk_sec <= 6'd0;
    end else begin
      state <= state_nxt;
      timer <= timer_nxt;

      // Serving the request wins over a req seen in the same cycle.
      if (walk_entry)                  pending <= 1'b0;
      else if (req && state != WALK)   pending <= 1'b1;

      car_g   <= (state_nxt == GREEN);
      car_y   <= (state_nxt == YELLOW);
      car_r   <= (state_nxt == ALLRED) || ped_nxt;
      pattern <= ped_nxt;

      if (!ped_nxt || walk_entry) sel <= 2'd0;
      else if (frame_tick)        sel <= sel + 2'd1;

      // Blank only toggles while staying in FLASH; entering or leaving forces it low.
      if (state == FLASH && state_nxt == FLASH) blank <= blank ^ tick;
      else                                      blank <= 1'b0;

      unique case (state_nxt)
        WALK:    walk_sec <= timer_nxt + FLASH_W;
        FLASH:   walk_sec <= timer_nxt;
        default: walk_sec <= 6'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_ped_signal_controller.sv
// Directed bench for ped_signal_controller: a cycle model feeds a scoreboard queue
// of expected outputs, plus directed checks of the countdown, animation and reset behaviour.
module tb_ped_signal_controller;

  localparam int MIN_GREEN = 2;
  localparam int YELLOW_T  = 1;
  localparam int ALLRED_T  = 1;
  localparam int WALK_T    = 3;
  localparam int FLASH_T   = 2;

  localparam int S_GREEN = 0, S_YELLOW = 1, S_ALLRED = 2, S_WALK = 3, S_FLASH = 4;

  typedef struct packed {
    logic       pattern;
    logic [1:0] sel;
    logic       blank;
    logic       car_r;
    logic       car_y;
    logic       car_g;
    logic [5:0] walk_sec;
    logic       pending;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst, tick, frame_tick, req;
  logic       pattern, blank, car_r, car_y, car_g, pending;
  logic [1:0] sel;
  logic [5:0] walk_sec;

  int checks = 0;
  int errors = 0;
  obs_t sb_q[$];

  int ms, mt, msel;
  bit mp, mblank;

  ped_signal_controller #(
    .MIN_GREEN(MIN_GREEN), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .WALK_T(WALK_T), .FLASH_T(FLASH_T)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .frame_tick(frame_tick), .req(req),
    .pattern(pattern), .sel(sel), .blank(blank),
    .car_r(car_r), .car_y(car_y), .car_g(car_g),
    .walk_sec(walk_sec), .pending(pending)
  );

  always #5 clk = ~clk;

  function automatic int dur(input int s);
    case (s)
      S_GREEN:  return MIN_GREEN;
      S_YELLOW: return YELLOW_T;
      S_ALLRED: return ALLRED_T;
      S_WALK:   return WALK_T;
      default:  return FLASH_T;
    endcase
  endfunction

  task automatic model_reset();
    ms = S_GREEN; mt = MIN_GREEN; mp = 1'b0; msel = 0; mblank = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit f, input bit r);
    int ns = ms;
    int nt = mt;
    bit np = mp;
    if (r && ms != S_WALK) np = 1'b1;
    if (ms == S_GREEN) begin
      if (mt == 0 && mp) begin ns = S_YELLOW; nt = YELLOW_T; end
      else if (t && mt > 0) nt = mt - 1;
    end else if (t) begin
      if (mt == 1) begin
        ns = (ms == S_FLASH) ? S_GREEN : ms + 1;
        nt = dur(ns);
      end else nt = mt - 1;
    end
    if (ms == S_ALLRED && ns == S_WALK) np = 1'b0;
    if (ns == S_WALK && ms != S_WALK) msel = 0;
    else if (ns == S_WALK || ns == S_FLASH) msel = f ? (msel + 1) % 4 : msel;
    else msel = 0;
    mblank = (ns == S_FLASH && ms == S_FLASH) ? (mblank ^ t) : 1'b0;
    ms = ns; mt = nt; mp = np;
  endtask

  function automatic obs_t model_obs();
    obs_t o;
    o.pattern  = (ms == S_WALK || ms == S_FLASH);
    o.sel      = 2'(msel);
    o.blank    = mblank;
    o.car_g    = (ms == S_GREEN);
    o.car_y    = (ms == S_YELLOW);
    o.car_r    = (ms >= S_ALLRED);
    o.walk_sec = (ms == S_WALK) ? 6'(mt + FLASH_T) : (ms == S_FLASH) ? 6'(mt) : 6'd0;
    o.pending  = mp;
    return o;
  endfunction

  function automatic obs_t dut_obs();
    return {pattern, sel, blank, car_r, car_y, car_g, walk_sec, pending};
  endfunction

  task automatic check_obs(input string tag, input obs_t exp);
    obs_t got = dut_obs();
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // One clock: drive inputs, queue the model's prediction, compare after the edge.
  task automatic cycle(input bit t, input bit f, input bit r, input string tag);
    obs_t exp;
    tick = t; frame_tick = f; req = r;
    model_step(t, f, r);
    sb_q.push_back(model_obs());
    @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    check_obs(tag, exp);
    tick = 1'b0; frame_tick = 1'b0; req = 1'b0;
  endtask

  // Asynchronous reset: outputs must change before any clock edge.
  task automatic do_reset(input string tag);
    rst = 1'b1;
    #2;
    model_reset();
    sb_q.delete();
    check_obs(tag, model_obs());
    chk({tag, "_car_g"}, car_g, 1);
    chk({tag, "_pending"}, pending, 0);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    int wsec_q[$];
    int sel_q[$];
    int exp_wsec[5] = '{5, 4, 3, 2, 1};
    int exp_sel[5]  = '{0, 1, 2, 3, 0};
    int blank_rises;
    int flash_age;
    bit prev_blank, seen_flash, reached_y, found;

    tick = 1'b0; frame_tick = 1'b0; req = 1'b0; rst = 1'b0;
    do_reset("reset_init");

    // Idle: no request keeps the crossing in GREEN however many ticks arrive.
    for (int i = 0; i < 20; i++) cycle(i % 2 == 1, 1'b0, 1'b0, "idle");
    chk("idle_car_g", car_g, 1);
    chk("idle_pattern", pattern, 0);
    chk("idle_pending", pending, 0);

    // Full pedestrian cycle: req pulse at cycle 1, tick every 4 cycles, frame_tick every cycle.
    do_reset("reset_cycle");
    blank_rises = 0;
    prev_blank  = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cycle(i % 4 == 3, 1'b1, i == 1, "cycle");
      if (pattern) begin
        if (sel_q.size() == 0) chk("walk_entry_pending", pending, 0);
        if (wsec_q.size() == 0 || wsec_q[$] != int'(walk_sec)) wsec_q.push_back(int'(walk_sec));
        if (walk_sec > 6'(FLASH_T)) sel_q.push_back(int'(sel));
        if (blank && !prev_blank) blank_rises++;
      end
      prev_blank = blank;
    end
    chk("walk_sec_count", wsec_q.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < wsec_q.size()) chk($sformatf("walk_sec_%0d", i), wsec_q[i], exp_wsec[i]);
    for (int i = 0; i < 5; i++)
      if (i < sel_q.size()) chk($sformatf("sel_%0d", i), sel_q[i], exp_sel[i]);
    chk("sel_samples", sel_q.size() >= 5, 1);
    chk("blank_toggles", blank_rises, 1);
    chk("end_car_g", car_g, 1);
    chk("end_sel", sel, 0);
    chk("end_walk_sec", walk_sec, 0);

    // req held high through WALK and FLASH: latched one cycle after FLASH entry.
    seen_flash = 1'b0;
    reached_y  = 1'b0;
    flash_age  = -1;
    for (int i = 0; i < 80 && !reached_y; i++) begin
      cycle(i % 2 == 1, 1'b0, 1'b1, "hold_req");
      if (flash_age >= 0) flash_age++;
      if (!seen_flash && pattern && walk_sec == 6'(FLASH_T)) begin
        seen_flash = 1'b1;
        flash_age  = 0;
        chk("flash_entry_pending", pending, 0);
      end
      if (flash_age == 1) chk("flash_latch_pending", pending, 1);
      if (seen_flash && car_y) reached_y = 1'b1;
    end
    chk("flash_seen", seen_flash, 1);
    chk("relatch_yellow", reached_y, 1);

    // Reset in the middle of WALK with req held high.
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cycle(i % 2 == 1, 1'b1, 1'b1, "to_walk");
      if (pattern && walk_sec == 6'(FLASH_T + 2)) found = 1'b1;
    end
    chk("mid_walk_found", found, 1);
    req = 1'b1;
    do_reset("reset_mid_walk");
    chk("reset_pattern", pattern, 0);
    cycle(1'b0, 1'b0, 1'b1, "post_reset_req");
    chk("post_reset_pending", pending, 1);
    for (int i = 0; i < 12; i++) cycle(i % 2 == 1, 1'b0, 1'b0, "post_reset_run");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
